// File: rtl/apb_completer_regs_if.sv
// ============================================================================
// apb_completer_regs_if : APB3 bus bundle between requester and completer
// Revision 1.0
// ============================================================================
`default_nettype none

interface apb_completer_regs_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_completer_regs.sv
// ============================================================================
// apb_completer_regs : APB3 completer with a read/write register bank,
//                      programmable wait states and pslverr decode.
// Revision 1.0
// ============================================================================
`default_nettype none

module apb_completer_regs #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  apb_completer_regs_if.slave     bus,
  output logic [32*NUM_REGS-1:0]  regs_q
);

  localparam int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_ACCESS    = 1'b1;
  localparam logic [3:0] C_WAIT      = 4'(WAIT_STATES);
  localparam logic       C_ZERO_WAIT = (WAIT_STATES == 0);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;
  logic [31:0] r_regs [NUM_REGS];

  logic             w_err_bus;
  logic             w_err_lat;
  logic [IDX_W-1:0] w_idx_bus;
  logic [IDX_W-1:0] w_idx_lat;
  logic [31:0]      w_rd_bus;
  logic [31:0]      w_rd_lat;

  function automatic logic f_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(NUM_REGS));
  endfunction

  // Zero-wait transfers complete off the live setup-phase address; all
  // others complete off the latched copy.
  assign w_err_bus = f_err(bus.paddr);
  assign w_err_lat = f_err(r_addr);
  assign w_idx_bus = bus.paddr[IDX_W+1:2];
  assign w_idx_lat = r_addr[IDX_W+1:2];
  assign w_rd_bus  = w_err_bus ? 32'h0 : r_regs[w_idx_bus];
  assign w_rd_lat  = w_err_lat ? 32'h0 : r_regs[w_idx_lat];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 32'h0;
      r_write   <= 1'b0;
      r_wdata   <= 32'h0;
      r_prdata  <= 32'h0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (r_state == S_IDLE) begin
      r_prdata  <= 32'h0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      if (bus.psel && !bus.penable) begin
        r_addr   <= bus.paddr;
        r_write  <= bus.pwrite;
        r_wdata  <= bus.pwdata;
        r_cnt    <= C_WAIT;
        r_state  <= S_ACCESS;
        r_pready <= C_ZERO_WAIT;
        if (C_ZERO_WAIT) begin
          r_pslverr <= w_err_bus;
          r_prdata  <= w_rd_bus;
        end
      end
    end else begin
      if (!bus.psel) begin
        // Requester abandoned the transfer: drop it without touching the bank.
        r_state   <= S_IDLE;
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
        r_prdata  <= 32'h0;
      end else if (bus.penable) begin
        if (r_pready) begin
          if (r_write && !w_err_lat) begin
            r_regs[w_idx_lat] <= r_wdata;
          end
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= 32'h0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_pready  <= 1'b1;
            r_pslverr <= w_err_lat;
            r_prdata  <= w_rd_lat;
          end
        end
      end
    end
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs_q[32*g +: 32] = r_regs[g];
    end
  endgenerate

endmodule

`default_nettype wire
